// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, key-action type and digit lookup
// for the numeric-entry keyboard block.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;

    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;

    typedef enum logic [2:0] {
        KEY_NONE,
        KEY_DIGIT,
        KEY_BKSP,
        KEY_ESC,
        KEY_ENTER
    } key_act_e;

    // Returns {valid, bcd}. Main-row digits never carry E0; keypad digits
    // are accepted with or without the E0 prefix.
    function automatic logic [4:0] scan_to_bcd(input logic [7:0] code, input logic ext);
        logic [4:0] main_r;
        logic [4:0] kp_r;
        main_r = '0;
        kp_r   = '0;
        case (code)
            8'h45: main_r = 5'h10;
            8'h16: main_r = 5'h11;
            8'h1E: main_r = 5'h12;
            8'h26: main_r = 5'h13;
            8'h25: main_r = 5'h14;
            8'h2E: main_r = 5'h15;
            8'h36: main_r = 5'h16;
            8'h3D: main_r = 5'h17;
            8'h3E: main_r = 5'h18;
            8'h46: main_r = 5'h19;
            8'h70: kp_r   = 5'h10;
            8'h69: kp_r   = 5'h11;
            8'h72: kp_r   = 5'h12;
            8'h7A: kp_r   = 5'h13;
            8'h6B: kp_r   = 5'h14;
            8'h73: kp_r   = 5'h15;
            8'h74: kp_r   = 5'h16;
            8'h6C: kp_r   = 5'h17;
            8'h75: kp_r   = 5'h18;
            8'h7D: kp_r   = 5'h19;
            default: begin
                main_r = '0;
                kp_r   = '0;
            end
        endcase
        return ext ? kp_r : (main_r | kp_r);
    endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit
// shift/check (start, odd parity, stop) and partial-frame timeout.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   valid_q, valid_d;
    logic                   err_q, err_d;
    logic [7:0]             byte_q, byte_d;

    logic fall;
    logic data_bit;

    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], PS2_DATA};
        clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
        fall        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
        data_bit    = data_sync_q[SYNC_STAGES-1];

        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tmo_d     = tmo_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        byte_d    = byte_q;

        if (fall) begin
            tmo_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                // shift_q holds bits 0..9 with the start bit at [0]; data_bit is the stop bit
                bit_cnt_d = '0;
                if (!shift_q[0] && data_bit && (^shift_q[9:1])) begin
                    valid_d = 1'b1;
                    byte_d  = shift_q[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                shift_d   = {data_bit, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != '0) begin
            if (tmo_q == TMO_LAST) begin
                bit_cnt_d = '0;
                tmo_d     = '0;
                err_d     = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tmo_q       <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            byte_q      <= '0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_q       <= tmo_d;
            valid_q     <= valid_d;
            err_q       <= err_d;
            byte_q      <= byte_d;
        end
    end

    assign rx_valid = valid_q;
    assign rx_byte  = byte_q;
    assign rx_err   = err_q;

endmodule

// File: rtl/ps2_digit_entry.sv
// PS/2 numeric-entry block: decodes release events into BCD digit slots
// with Backspace, Escape and Enter handling.
module ps2_digit_entry
    import ps2_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 3,
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                              CLK,
    input  logic                              reset,
    input  logic                              PS2_CLK,
    input  logic                              PS2_DATA,
    output logic [4*NUM_DIGITS-1:0]           oDigits,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   oCount,
    output logic                              oNumRdy,
    output logic                              oFrameErr,
    output logic [7:0]                        oLED
);

    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
    localparam logic [CW-1:0] FULL = CW'(NUM_DIGITS);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_err;

    ps2_rx_frame #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .CLK      (CLK),
        .reset    (reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DATA (PS2_DATA),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_err   (rx_err)
    );

    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    rdy_q, rdy_d;
    logic                    clr_q, clr_d;
    logic                    ext_q, ext_d;
    logic                    brk_q, brk_d;
    logic [7:0]              led_q, led_d;

    logic [4:0]  bcd_r;
    key_act_e    act;
    int unsigned slot;

    always_comb begin
        bcd_r = scan_to_bcd(rx_byte, ext_q);
        slot  = 32'(count_q);
        act   = KEY_NONE;
        if (bcd_r[4]) begin
            act = KEY_DIGIT;
        end else begin
            case (rx_byte)
                SC_BKSP:  act = KEY_BKSP;
                SC_ESC:   act = KEY_ESC;
                SC_ENTER: act = KEY_ENTER;
                default:  act = KEY_NONE;
            endcase
        end

        digits_d = digits_q;
        count_d  = count_q;
        rdy_d    = 1'b0;
        clr_d    = 1'b0;
        ext_d    = ext_q;
        brk_d    = brk_q;
        led_d    = led_q;

        // Enter holds the count for the ready cycle, then empties the entry
        if (clr_q) begin
            count_d = '0;
        end

        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            led_d = rx_byte;
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (brk_q) begin
                    case (act)
                        KEY_DIGIT: begin
                            if (count_q < FULL) begin
                                digits_d[4*slot +: 4] = bcd_r[3:0];
                                count_d = count_q + CW'(1);
                            end
                        end
                        KEY_BKSP: begin
                            if (count_q != '0) begin
                                digits_d[4*(slot-1) +: 4] = '0;
                                count_d = count_q - CW'(1);
                            end
                        end
                        KEY_ESC: begin
                            digits_d = '0;
                            count_d  = '0;
                        end
                        KEY_ENTER: begin
                            if (count_q == FULL) begin
                                rdy_d = 1'b1;
                                clr_d = 1'b1;
                            end
                        end
                        default: begin
                            digits_d = digits_q;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            digits_q <= '0;
            count_q  <= '0;
            rdy_q    <= 1'b0;
            clr_q    <= 1'b0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            led_q    <= '0;
        end else begin
            digits_q <= digits_d;
            count_q  <= count_d;
            rdy_q    <= rdy_d;
            clr_q    <= clr_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            led_q    <= led_d;
        end
    end

    assign oDigits   = digits_q;
    assign oCount    = count_q;
    assign oNumRdy   = rdy_q;
    assign oFrameErr = rx_err;
    assign oLED      = led_q;

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Directed bench for ps2_digit_entry: a 3-digit and a 1-digit instance
// share the same PS/2 lines.
module tb_ps2_digit_entry;

    localparam int unsigned TMO = 100;
    localparam int unsigned H   = 8;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic PS2_CLK = 1'b1;
    logic PS2_DATA = 1'b1;

    logic [11:0] d3_digits;
    logic [1:0]  d3_count;
    logic        d3_rdy, d3_err;
    logic [7:0]  d3_led;
    logic [3:0]  d1_digits;
    logic [0:0]  d1_count;
    logic        d1_rdy, d1_err;
    logic [7:0]  d1_led;

    int checks = 0;
    int failures = 0;

    int rdy3_n = 0;
    int err3_n = 0;
    int rdy1_n = 0;
    logic [11:0] cap3_digits = '0;
    logic [1:0]  cap3_count = '0;
    logic [3:0]  cap1_digits = '0;

    ps2_digit_entry #(
        .NUM_DIGITS  (3),
        .TIMEOUT_CYC (TMO),
        .SYNC_STAGES (2)
    ) dut3 (
        .CLK       (CLK),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .oDigits   (d3_digits),
        .oCount    (d3_count),
        .oNumRdy   (d3_rdy),
        .oFrameErr (d3_err),
        .oLED      (d3_led)
    );

    ps2_digit_entry #(
        .NUM_DIGITS  (1),
        .TIMEOUT_CYC (TMO),
        .SYNC_STAGES (2)
    ) dut1 (
        .CLK       (CLK),
        .reset     (reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .oDigits   (d1_digits),
        .oCount    (d1_count),
        .oNumRdy   (d1_rdy),
        .oFrameErr (d1_err),
        .oLED      (d1_led)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (d3_rdy) begin
            rdy3_n      <= rdy3_n + 1;
            cap3_digits <= d3_digits;
            cap3_count  <= d3_count;
        end
        if (d3_err) err3_n <= err3_n + 1;
        if (d1_rdy) begin
            rdy1_n      <= rdy1_n + 1;
            cap1_digits <= d1_digits;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
    endtask

    task automatic send_bits(input logic [10:0] f, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = f[i];
            wait_cyc(H);
            PS2_CLK = 1'b0;
            wait_cyc(H);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_bits(mk_frame(b, bad_par), 11);
        wait_cyc(2 * H);
    endtask

    task automatic press(input logic [7:0] b);
        send_byte(b, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(b, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cyc(4);
        reset = 1'b0;
        @(negedge CLK);
        checks++; if (d3_digits !== 12'h000) begin failures++; $display("FAIL reset_digits: got %h expected 000", d3_digits); end
        checks++; if (d3_count !== 2'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", d3_count); end
        checks++; if (d3_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", d3_rdy); end
        checks++; if (d3_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", d3_err); end
        checks++; if (d3_led !== 8'h00) begin failures++; $display("FAIL reset_led: got %h expected 00", d3_led); end
        checks++; if (d1_digits !== 4'h0) begin failures++; $display("FAIL reset_d1_digits: got %h expected 0", d1_digits); end
    endtask

    task automatic test_basic_entry;
        int r0;
        r0 = rdy3_n;
        press(8'h16);
        press(8'h1E);
        press(8'h26);
        press(8'h5A);
        checks++; if (rdy3_n - r0 !== 1) begin failures++; $display("FAIL basic_pulses: got %0d expected 1", rdy3_n - r0); end
        checks++; if (cap3_digits !== 12'h321) begin failures++; $display("FAIL basic_digits: got %h expected 321", cap3_digits); end
        checks++; if (cap3_count !== 2'd3) begin failures++; $display("FAIL basic_count_at_rdy: got %0d expected 3", cap3_count); end
        checks++; if (d3_count !== 2'd0) begin failures++; $display("FAIL basic_count_after: got %0d expected 0", d3_count); end
        checks++; if (d3_led !== 8'h5A) begin failures++; $display("FAIL basic_led: got %h expected 5a", d3_led); end
    endtask

    task automatic test_backspace;
        int r0;
        r0 = rdy3_n;
        press(8'h25);
        press(8'h2E);
        press(8'h66);
        press(8'h3D);
        press(8'h3E);
        press(8'h5A);
        checks++; if (rdy3_n - r0 !== 1) begin failures++; $display("FAIL bksp_pulses: got %0d expected 1", rdy3_n - r0); end
        checks++; if (cap3_digits !== 12'h874) begin failures++; $display("FAIL bksp_digits: got %h expected 874", cap3_digits); end
        r0 = rdy3_n;
        press(8'h25);
        press(8'h2E);
        press(8'h5A);
        checks++; if (rdy3_n - r0 !== 0) begin failures++; $display("FAIL short_enter_pulses: got %0d expected 0", rdy3_n - r0); end
        checks++; if (d3_count !== 2'd2) begin failures++; $display("FAIL short_enter_count: got %0d expected 2", d3_count); end
        press(8'h76);
        checks++; if (d3_count !== 2'd0) begin failures++; $display("FAIL esc_count: got %0d expected 0", d3_count); end
        checks++; if (d3_digits !== 12'h000) begin failures++; $display("FAIL esc_digits: got %h expected 000", d3_digits); end
        press(8'h66);
        checks++; if (d3_count !== 2'd0) begin failures++; $display("FAIL bksp_at_zero: got %0d expected 0", d3_count); end
        press(8'h16);
        press(8'h1E);
        press(8'h26);
        press(8'h46);
        checks++; if (d3_count !== 2'd3) begin failures++; $display("FAIL full_count: got %0d expected 3", d3_count); end
        checks++; if (d3_digits !== 12'h321) begin failures++; $display("FAIL full_no_overwrite: got %h expected 321", d3_digits); end
        press(8'h76);
    endtask

    task automatic test_parity_error;
        int e0;
        logic [1:0] c0;
        logic [7:0] l0;
        e0 = err3_n;
        c0 = d3_count;
        l0 = d3_led;
        send_byte(8'h16, 1'b1);
        checks++; if (err3_n - e0 !== 1) begin failures++; $display("FAIL parity_err_pulses: got %0d expected 1", err3_n - e0); end
        checks++; if (d3_count !== c0) begin failures++; $display("FAIL parity_count: got %0d expected %0d", d3_count, c0); end
        checks++; if (d3_led !== l0) begin failures++; $display("FAIL parity_led: got %h expected %h", d3_led, l0); end
        press(8'h16);
        checks++; if (d3_count !== 2'd1) begin failures++; $display("FAIL after_parity_count: got %0d expected 1", d3_count); end
        checks++; if (d3_digits !== 12'h001) begin failures++; $display("FAIL after_parity_digits: got %h expected 001", d3_digits); end
        checks++; if (d3_led !== 8'h16) begin failures++; $display("FAIL after_parity_led: got %h expected 16", d3_led); end
        press(8'h76);
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err3_n;
        send_bits(mk_frame(8'h45, 1'b0), 5);
        wait_cyc(TMO + 20);
        checks++; if (err3_n - e0 !== 1) begin failures++; $display("FAIL timeout_err_pulses: got %0d expected 1", err3_n - e0); end
        checks++; if (dut3.u_rx.bit_cnt_q !== 4'd0) begin failures++; $display("FAIL timeout_bitcnt: got %0d expected 0", dut3.u_rx.bit_cnt_q); end
        send_byte(8'h45, 1'b0);
        checks++; if (d3_led !== 8'h45) begin failures++; $display("FAIL timeout_next_led: got %h expected 45", d3_led); end
        checks++; if (err3_n - e0 !== 1) begin failures++; $display("FAIL timeout_next_no_err: got %0d expected 1", err3_n - e0); end
    endtask

    task automatic test_keypad_n1;
        int r1;
        int r3;
        press(8'h76);
        r1 = rdy1_n;
        r3 = rdy3_n;
        send_byte(8'hE0, 1'b0); send_byte(8'h69, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h69, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'h5A, 1'b0);
        send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h5A, 1'b0);
        checks++; if (rdy1_n - r1 !== 1) begin failures++; $display("FAIL kp_n1_pulses: got %0d expected 1", rdy1_n - r1); end
        checks++; if (cap1_digits !== 4'h1) begin failures++; $display("FAIL kp_n1_digits: got %h expected 1", cap1_digits); end
        checks++; if (d1_count !== 1'b0) begin failures++; $display("FAIL kp_n1_count_after: got %0d expected 0", d1_count); end
        checks++; if (rdy3_n - r3 !== 0) begin failures++; $display("FAIL kp_n3_pulses: got %0d expected 0", rdy3_n - r3); end
        checks++; if (d3_digits !== 12'h001) begin failures++; $display("FAIL kp_n3_digits: got %h expected 001", d3_digits); end
        press(8'h76);
        send_byte(8'h16, 1'b0); send_byte(8'h16, 1'b0); send_byte(8'h16, 1'b0);
        send_byte(8'hF0, 1'b0); send_byte(8'h16, 1'b0);
        checks++; if (d3_count !== 2'd1) begin failures++; $display("FAIL typematic_count: got %0d expected 1", d3_count); end
        checks++; if (d3_digits !== 12'h001) begin failures++; $display("FAIL typematic_digits: got %h expected 001", d3_digits); end
    endtask

    task automatic test_reset_mid;
        int r0;
        int e0;
        press(8'h76);
        press(8'h25);
        press(8'h2E);
        checks++; if (d3_count !== 2'd2) begin failures++; $display("FAIL mid_pre_count: got %0d expected 2", d3_count); end
        send_bits(mk_frame(8'h16, 1'b0), 5);
        @(posedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        checks++; if (d3_digits !== 12'h000) begin failures++; $display("FAIL mid_digits: got %h expected 000", d3_digits); end
        checks++; if (d3_count !== 2'd0) begin failures++; $display("FAIL mid_count: got %0d expected 0", d3_count); end
        checks++; if (d3_led !== 8'h00) begin failures++; $display("FAIL mid_led: got %h expected 00", d3_led); end
        r0 = rdy3_n;
        e0 = err3_n;
        wait_cyc(3 * TMO);
        checks++; if (rdy3_n - r0 !== 0) begin failures++; $display("FAIL mid_spurious_rdy: got %0d expected 0", rdy3_n - r0); end
        checks++; if (err3_n - e0 !== 0) begin failures++; $display("FAIL mid_spurious_err: got %0d expected 0", err3_n - e0); end
    endtask

    initial begin
        test_reset;
        test_basic_entry;
        test_backspace;
        test_parity_error;
        test_timeout;
        test_keypad_n1;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
